// File: rtl/fine_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module : fine_delay_pkg
// Brief  : Shared constants and FSM state type for the fine delay scheduler.
// Rev    : 1.0
// ============================================================================
package fine_delay_pkg;

  localparam int STEPS_PER_PERIOD_DEFAULT = 497;
  localparam int PS_PER_STEP_DEFAULT      = 20;
  localparam int HALF_PERIOD_STEPS        = 248;
  localparam int TIMEOUT_CYC_DEFAULT      = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    PULSE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fine_delay_ps2steps.sv
`default_nettype none
// ============================================================================
// Module : fine_delay_ps2steps
// Brief  : Combinational picosecond-to-phase-step conversion with saturation.
// Rev    : 1.0
// ============================================================================
module fine_delay_ps2steps
  import fine_delay_pkg::*;
#(
  parameter int STEPS_PER_PERIOD = STEPS_PER_PERIOD_DEFAULT,
  parameter int PS_PER_STEP      = PS_PER_STEP_DEFAULT
) (
  input  logic [15:0] delay_ps_i,
  output logic [8:0]  steps_o
);

  localparam logic [15:0] MAX_STEP = 16'(STEPS_PER_PERIOD - 1);

  logic [15:0] w_quot;

  always_comb begin
    w_quot = delay_ps_i / 16'(PS_PER_STEP);
    if (w_quot > MAX_STEP) begin
      steps_o = 9'(MAX_STEP);
    end else begin
      steps_o = 9'(w_quot);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fine_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fine_delay_scheduler
// Brief  : Arbitrates host/sweep delay requests and steps the MMCM fine phase
//          along the shortest path around the period to the requested target.
// Rev    : 1.0
// ============================================================================
module fine_delay_scheduler
  import fine_delay_pkg::*;
#(
  parameter int STEPS_PER_PERIOD = STEPS_PER_PERIOD_DEFAULT,
  parameter int PS_PER_STEP      = PS_PER_STEP_DEFAULT,
  parameter int TIMEOUT_CYC      = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [15:0] host_delay_ps,
  input  logic        sweep_valid,
  output logic        sweep_ready,
  input  logic [15:0] sweep_delay_ps,
  input  logic        mmcm_locked,
  output logic        ps_en,
  output logic        ps_incdec,
  input  logic        ps_done,
  output logic        busy,
  output logic        done,
  output logic        done_src,
  output logic [8:0]  current_steps,
  output logic        err_timeout,
  output logic        err_lock
);

  localparam int          TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int          HALF     = STEPS_PER_PERIOD / 2;
  localparam logic [8:0]  MAX_STEP = 9'(STEPS_PER_PERIOD - 1);

  state_e             state_q, state_d;
  logic [8:0]         cur_q, cur_d;
  logic [8:0]         rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               src_q, src_d;
  logic [15:0]        delay_q, delay_d;
  logic               prio_q, prio_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_to_q, err_to_d;
  logic               err_lk_q, err_lk_d;
  logic               locked_q;

  logic [8:0]         w_target;
  logic [9:0]         w_diff;
  logic               w_ready;
  logic               w_tie;
  logic               w_pick_sweep;
  logic               w_lock_fall;

  fine_delay_ps2steps #(
    .STEPS_PER_PERIOD (STEPS_PER_PERIOD),
    .PS_PER_STEP      (PS_PER_STEP)
  ) u_ps2steps (
    .delay_ps_i (delay_q),
    .steps_o    (w_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      src_q    <= 1'b0;
      delay_q  <= '0;
      prio_q   <= 1'b0;
      tmo_q    <= '0;
      err_to_q <= 1'b0;
      err_lk_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      src_q    <= src_d;
      delay_q  <= delay_d;
      prio_q   <= prio_d;
      tmo_q    <= tmo_d;
      err_to_q <= err_to_d;
      err_lk_q <= err_lk_d;
      locked_q <= mmcm_locked;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    src_d    = src_q;
    delay_d  = delay_q;
    prio_d   = prio_q;
    tmo_d    = tmo_q;
    err_to_d = err_to_q;
    err_lk_d = err_lk_q;

    w_lock_fall  = locked_q & ~mmcm_locked;
    w_ready      = (state_q == IDLE) & mmcm_locked;
    w_tie        = host_valid & sweep_valid;
    // prio_q set means the sweep engine owns the next tie
    w_pick_sweep = w_tie ? prio_q : sweep_valid;

    if (w_target >= cur_q) begin
      w_diff = {1'b0, w_target} - {1'b0, cur_q};
    end else begin
      w_diff = {1'b0, w_target} + 10'(STEPS_PER_PERIOD) - {1'b0, cur_q};
    end

    if (w_lock_fall) begin
      state_d  = IDLE;
      cur_d    = '0;
      err_lk_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_ready && (host_valid || sweep_valid)) begin
            src_d    = w_pick_sweep;
            delay_d  = w_pick_sweep ? sweep_delay_ps : host_delay_ps;
            err_to_d = 1'b0;
            err_lk_d = 1'b0;
            if (w_tie) prio_d = ~w_pick_sweep;
            state_d  = CALC;
          end
        end
        CALC: begin
          if (w_diff == 10'd0) begin
            state_d = DONE;
          end else if (w_diff <= 10'(HALF)) begin
            rem_d   = 9'(w_diff);
            dir_d   = 1'b1;
            state_d = PULSE;
          end else begin
            rem_d   = 9'(10'(STEPS_PER_PERIOD) - w_diff);
            dir_d   = 1'b0;
            state_d = PULSE;
          end
        end
        PULSE: begin
          tmo_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (ps_done) begin
            if (dir_q) cur_d = (cur_q == MAX_STEP) ? 9'd0 : cur_q + 9'd1;
            else       cur_d = (cur_q == 9'd0) ? MAX_STEP : cur_q - 9'd1;
            rem_d   = rem_q - 9'd1;
            state_d = (rem_q == 9'd1) ? DONE : PULSE;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            err_to_d = 1'b1;
            state_d  = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign host_ready    = w_ready;
  assign sweep_ready   = w_ready;
  assign ps_en         = (state_q == PULSE) & mmcm_locked;
  assign ps_incdec     = dir_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE) & mmcm_locked;
  assign done_src      = src_q;
  assign current_steps = cur_q;
  assign err_timeout   = err_to_q;
  assign err_lock      = err_lk_q;

endmodule
`default_nettype wire

// File: tb/tb_fine_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fine_delay_scheduler
// Brief  : Randomized self-checking bench with an MMCM responder and a
//          shortest-path phase model.
// Rev    : 1.0
// ============================================================================
module tb_fine_delay_scheduler;

  localparam int STEPS = 497;
  localparam int PSS   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid, sweep_valid, mmcm_locked, ps_done;
  logic [15:0] host_delay_ps, sweep_delay_ps;
  logic        host_ready, sweep_ready, ps_en, ps_incdec, busy, done, done_src;
  logic [8:0]  current_steps;
  logic        err_timeout, err_lock;

  int checks = 0;
  int errors = 0;

  int model_cur  = 0;
  int mmcm_phase = 0;
  int pulses     = 0;
  int done_cnt   = 0;
  int cnt        = 0;
  bit exp_dir    = 1'b1;
  bit suppress   = 1'b0;
  bit pend       = 1'b0;
  bit prev_en    = 1'b0;
  bit rr_sweep   = 1'b0;

  fine_delay_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_delay_ps  (host_delay_ps),
    .sweep_valid    (sweep_valid),
    .sweep_ready    (sweep_ready),
    .sweep_delay_ps (sweep_delay_ps),
    .mmcm_locked    (mmcm_locked),
    .ps_en          (ps_en),
    .ps_incdec      (ps_incdec),
    .ps_done        (ps_done),
    .busy           (busy),
    .done           (done),
    .done_src       (done_src),
    .current_steps  (current_steps),
    .err_timeout    (err_timeout),
    .err_lock       (err_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void plan(input int cur, input int dly, output int np,
                               output bit dir, output int fin);
    int tgt, fwd;
    tgt = dly / PSS;
    if (tgt > STEPS - 1) tgt = STEPS - 1;
    fwd = (tgt - cur + STEPS) % STEPS;
    dir = 1'b1;
    if (fwd == 0) np = 0;
    else if (fwd <= STEPS / 2) np = fwd;
    else begin
      np  = STEPS - fwd;
      dir = 1'b0;
    end
    fin = tgt;
  endfunction

  // MMCM responder: answers each strobe 1..4 cycles later and tracks phase
  initial begin
    ps_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ps_done) pend = 1'b0;
      ps_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (suppress) pend = 1'b0;
          else ps_done = 1'b1;
        end
      end
      if (ps_en) begin
        check("ps_en_back2back", 32'(prev_en), 0);
        check("ps_en_outstanding", 32'(pend), 0);
        check("ps_incdec", 32'(ps_incdec), 32'(exp_dir));
        pulses++;
        mmcm_phase = ps_incdec ? (mmcm_phase + 1) % STEPS : (mmcm_phase + STEPS - 1) % STEPS;
        pend = 1'b1;
        cnt  = int'($urandom_range(1, 4));
      end
      prev_en = ps_en;
      if (done) done_cnt++;
    end
  end

  task automatic run_job(input bit vh, input bit vs, input int dh, input int ds);
    int np, fin, w;
    bit win, dir;
    w = 0;
    while (!host_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(host_ready), 1);
    win = (vh && vs) ? rr_sweep : vs;
    if (vh && vs) rr_sweep = !win;
    plan(model_cur, win ? ds : dh, np, dir, fin);
    exp_dir = dir;
    pulses  = 0;
    host_valid = vh; sweep_valid = vs;
    host_delay_ps = 16'(dh); sweep_delay_ps = 16'(ds);
    @(negedge clk);
    host_valid = 1'b0; sweep_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 32'(done), 1);
    check("done_src", 32'(done_src), 32'(win));
    check("pulse_count", pulses, np);
    check("current_steps", 32'(current_steps), fin);
    check("mmcm_phase", 32'(current_steps), mmcm_phase);
    check("err_timeout_clr", 32'(err_timeout), 0);
    check("err_lock_clr", 32'(err_lock), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    model_cur = fin;
  endtask

  task automatic run_timeout();
    int n, d0;
    d0 = done_cnt;
    suppress = 1'b1;
    exp_dir  = 1'b1;
    host_valid = 1'b1;
    host_delay_ps = 16'(((model_cur + 30) % STEPS) * PSS);
    @(negedge clk);
    host_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, 66);
    check("err_timeout_set", 32'(err_timeout), 1);
    check("timeout_ready", 32'(host_ready), 1);
    check("timeout_cur", 32'(current_steps), model_cur);
    repeat (6) @(negedge clk);
    check("timeout_no_done", 32'(done_cnt == d0), 1);
    suppress   = 1'b0;
    mmcm_phase = model_cur;
  endtask

  task automatic run_lock_drop();
    int w, d0;
    d0 = done_cnt;
    exp_dir = 1'b1;
    pulses  = 0;
    sweep_valid = 1'b1;
    sweep_delay_ps = 16'(((model_cur + 150) % STEPS) * PSS);
    @(negedge clk);
    sweep_valid = 1'b0;
    w = 0;
    while (pulses < 5 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("lock_mid_sweep", 32'(busy), 1);
    mmcm_locked = 1'b0;
    @(negedge clk);
    check("lock_idle", 32'(busy), 0);
    check("lock_cur_zero", 32'(current_steps), 0);
    check("lock_err", 32'(err_lock), 1);
    check("lock_host_ready", 32'(host_ready), 0);
    check("lock_sweep_ready", 32'(sweep_ready), 0);
    repeat (8) @(negedge clk);
    check("lock_ready_held", 32'(sweep_ready), 0);
    check("lock_no_done", 32'(done_cnt == d0), 1);
    mmcm_locked = 1'b1;
    @(negedge clk);
    check("relock_ready", 32'(sweep_ready), 1);
    check("lock_err_sticky", 32'(err_lock), 1);
    model_cur  = 0;
    mmcm_phase = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, r, dh, ds, w;
    rst = 1'b1; mmcm_locked = 1'b0;
    host_valid = 1'b0; sweep_valid = 1'b0;
    host_delay_ps = '0; sweep_delay_ps = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ps_en", 32'(ps_en), 0);
    check("rst_cur", 32'(current_steps), 0);
    check("rst_errs", {30'd0, err_timeout, err_lock}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("unlocked_ready", 32'(host_ready), 0);
    mmcm_locked = 1'b1;
    @(negedge clk);
    check("locked_ready", 32'({host_ready, sweep_ready}), 3);

    run_job(1, 0, 1000, 0);      // 50 increments
    run_job(1, 0, 9800, 0);      // to 490
    run_job(0, 1, 0, 200);       // 17 increments with wrap
    run_job(1, 0, 9940, 0);      // saturate to 496
    run_job(1, 0, 200, 0);       // back to 10
    run_job(1, 0, 9999, 0);      // 11 decrements through 0
    run_job(1, 1, 3000, 5000);   // first tie -> host
    run_job(1, 1, 7000, 1000);   // second tie -> sweep
    run_job(1, 0, model_cur * PSS + 7, 0);  // zero distance
    run_timeout();
    run_job(0, 1, 0, 4000);
    run_lock_drop();
    run_job(1, 0, 6000, 0);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 9));
      r    = int'($urandom_range(0, 9));
      dh   = int'($urandom_range(0, 9939));
      ds   = int'($urandom_range(0, 9939));
      if (r == 0) begin
        dh = int'($urandom_range(9940, 65535));
        ds = 65535;
      end else if (r == 1) begin
        dh = model_cur * PSS + int'($urandom_range(0, 19));
        ds = dh;
      end
      if (kind < 2)      run_job(1, 1, dh, ds);
      else if (kind < 6) run_job(1, 0, dh, 0);
      else               run_job(0, 1, 0, ds);
    end

    if (!rr_sweep) run_job(1, 1, 1200, 2400);
    exp_dir = 1'b1;
    host_valid = 1'b1;
    host_delay_ps = 16'(((model_cur + 100) % STEPS) * PSS);
    @(negedge clk);
    host_valid = 1'b0;
    w = 0;
    while (pulses < 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    pulses = 0;
    while (pulses < 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cur", 32'(current_steps), 0);
    check("midrst_ps_en", 32'(ps_en), 0);
    rst = 1'b0;
    rr_sweep   = 1'b0;
    model_cur  = 0;
    repeat (8) @(negedge clk);
    mmcm_phase = 0;
    run_job(1, 1, 2000, 4000);   // pointer back to host after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
